// File: rtl/timer_pkg.sv
// Shared definitions for the multi-channel timer register file.
//   - Register byte offsets (12-bit APB address space)
//   - TCR field positions and reset value
//   - Channel count upper limit
//   - merge_bytes: byte-lane merge of a write word onto an existing word
package timer_pkg;

  localparam logic [11:0] ADDR_TCR       = 12'h000;
  localparam logic [11:0] ADDR_TDR0      = 12'h004;
  localparam logic [11:0] ADDR_TDR1      = 12'h008;
  localparam logic [11:0] ADDR_TCMP0_LO  = 12'h010;
  localparam logic [11:0] ADDR_TIER      = 12'h100;
  localparam logic [11:0] ADDR_TISR      = 12'h104;
  localparam logic [11:0] ADDR_THCSR     = 12'h108;

  // Each channel owns one 8-byte slot; this is the slot index of channel 0.
  localparam logic [8:0]  TCMP_SLOT_BASE = ADDR_TCMP0_LO[11:3];

  localparam int          TCR_EN_BIT      = 0;
  localparam int          TCR_DIV_EN_BIT  = 1;
  localparam int          TCR_DIV_VAL_LSB = 8;
  localparam logic [31:0] TCR_RST         = 32'h0000_0100;

  localparam int          NUM_CH_MAX      = 8;

  function automatic logic [31:0] merge_bytes(input logic [31:0] old_w,
                                              input logic [31:0] new_w,
                                              input logic [3:0]  strb);
    logic [31:0] res;
    for (int b = 0; b < 4; b++) begin
      res[8*b +: 8] = strb[b] ? new_w[8*b +: 8] : old_w[8*b +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/timer_irq_ch.sv
// One interrupt channel: a pending bit set by a compare-hit pulse and
// cleared by a write-1-to-clear request (set wins when both arrive in the
// same cycle), plus enable gating of the request line.
// Ports:
//   sys_clk, sys_rst_n : clock, asynchronous active-low reset
//   set_pulse          : compare-hit pulse from the core
//   clr_req            : W1C request for this bit
//   enable             : interrupt enable bit
//   pending            : registered pending status
//   irq                : pending & enable
module timer_irq_ch
  import timer_pkg::*;
(
  input  logic sys_clk,
  input  logic sys_rst_n,
  input  logic set_pulse,
  input  logic clr_req,
  input  logic enable,
  output logic pending,
  output logic irq
);

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      pending <= 1'b0;
    end else if (set_pulse) begin
      pending <= 1'b1;
    end else if (clr_req) begin
      pending <= 1'b0;
    end
  end

  assign irq = pending & enable;

endmodule

// File: rtl/timer_regfile_mc.sv
// Register file for the multi-channel timer: control, per-channel 64-bit
// compare values, interrupt enable/status and halt handshake, with an
// atomic 64-bit counter read through a shadow of the upper word.
// Ports:
//   sys_clk, sys_rst_n          : clock, asynchronous active-low reset
//   wr_en, rd_en                : one-cycle access strobes from the APB front-end
//   tim_paddr/pwdata/pstrb      : address, write data, byte-lane enables
//   tim_prdata                  : registered read data
//   cnt_val                     : live 64-bit counter
//   halt_ack_status             : core halt acknowledge
//   cmp_match                   : per-channel compare-hit pulses
//   timer_en/div_en/div_val     : TCR fields to the core
//   halt_req                    : THCSR[0]
//   compare_val                 : channel i at [64i+:64]
//   counter_clear               : pulse on accepted timer_en 1->0
//   counter_write_sel/data      : one-cycle counter load command
//   tim_int                     : merged interrupt
//   reg_error_flag              : one-cycle access error pulse
module timer_regfile_mc
  import timer_pkg::*;
#(
  parameter int          NUM_CH  = 4,
  parameter int          DIV_W   = 4,
  parameter logic [63:0] CMP_RST = 64'hFFFF_FFFF_FFFF_FFFF
) (
  input  logic                sys_clk,
  input  logic                sys_rst_n,
  input  logic                wr_en,
  input  logic                rd_en,
  input  logic [11:0]         tim_paddr,
  input  logic [31:0]         tim_pwdata,
  input  logic [3:0]          tim_pstrb,
  output logic [31:0]         tim_prdata,
  input  logic [63:0]         cnt_val,
  input  logic                halt_ack_status,
  input  logic [NUM_CH-1:0]   cmp_match,
  output logic                timer_en,
  output logic                div_en,
  output logic [DIV_W-1:0]    div_val,
  output logic                halt_req,
  output logic [64*NUM_CH-1:0] compare_val,
  output logic                counter_clear,
  output logic [1:0]          counter_write_sel,
  output logic [31:0]         counter_write_data,
  output logic                tim_int,
  output logic                reg_error_flag
);

  logic               timer_en_q, div_en_q, halt_req_q;
  logic [DIV_W-1:0]   div_val_q;
  logic [NUM_CH-1:0]  tier_q;
  logic [31:0]        shadow_q;
  logic [63:0]        cmp_q [NUM_CH];
  logic [NUM_CH-1:0]  pend, irq;

  // Address decode
  logic sel_tcr, sel_tdr0, sel_tdr1, sel_tier, sel_tisr, sel_thcsr, mapped;
  logic [NUM_CH-1:0] sel_cmp;

  assign sel_tcr   = (tim_paddr == ADDR_TCR);
  assign sel_tdr0  = (tim_paddr == ADDR_TDR0);
  assign sel_tdr1  = (tim_paddr == ADDR_TDR1);
  assign sel_tier  = (tim_paddr == ADDR_TIER);
  assign sel_tisr  = (tim_paddr == ADDR_TISR);
  assign sel_thcsr = (tim_paddr == ADDR_THCSR);

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    assign sel_cmp[g] = (tim_paddr[11:3] == TCMP_SLOT_BASE + 9'(g)) &&
                        (tim_paddr[1:0] == 2'b00);
    assign compare_val[64*g +: 64] = cmp_q[g];

    timer_irq_ch u_irq (
      .sys_clk   (sys_clk),
      .sys_rst_n (sys_rst_n),
      .set_pulse (cmp_match[g]),
      .clr_req   (wr_en && sel_tisr && tim_pstrb[0] && tim_pwdata[g]),
      .enable    (tier_q[g]),
      .pending   (pend[g]),
      .irq       (irq[g])
    );
  end

  assign mapped = sel_tcr | sel_tdr0 | sel_tdr1 | sel_tier | sel_tisr |
                  sel_thcsr | (|sel_cmp);

  // TCR write evaluation: the divider must not be retuned while the timer
  // keeps running, but stopping it and retuning in one write is allowed.
  logic [31:0]      tcr_cur, tcr_new;
  logic             new_en, new_div_en, tcr_reject;
  logic [DIV_W-1:0] new_div_val;

  always_comb begin
    tcr_cur = '0;
    tcr_cur[TCR_EN_BIT]                  = timer_en_q;
    tcr_cur[TCR_DIV_EN_BIT]              = div_en_q;
    tcr_cur[TCR_DIV_VAL_LSB +: DIV_W]    = div_val_q;
  end

  assign tcr_new     = merge_bytes(tcr_cur, tim_pwdata, tim_pstrb);
  assign new_en      = tcr_new[TCR_EN_BIT];
  assign new_div_en  = tcr_new[TCR_DIV_EN_BIT];
  assign new_div_val = tcr_new[TCR_DIV_VAL_LSB +: DIV_W];
  assign tcr_reject  = timer_en_q && new_en &&
                       ((new_div_en != div_en_q) || (new_div_val != div_val_q));

  logic tcr_accept, rd_take, err_d;
  logic [31:0] tdr_wdata;

  assign tcr_accept = wr_en && sel_tcr && !tcr_reject;
  // A simultaneous write wins; the read is dropped.
  assign rd_take    = rd_en && !wr_en;
  assign err_d      = (wr_en && rd_en) ||
                      ((wr_en || rd_en) && !mapped) ||
                      (wr_en && sel_tcr && tcr_reject);
  // Lanes not written come from the live counter so the core reloads them unchanged.
  assign tdr_wdata  = merge_bytes(sel_tdr0 ? cnt_val[31:0] : cnt_val[63:32],
                                  tim_pwdata, tim_pstrb);

  // Read mux; unmapped addresses read as zero.
  logic [31:0] rd_mux;
  always_comb begin
    rd_mux = '0;
    if (sel_tcr)        rd_mux = tcr_cur;
    else if (sel_tdr0)  rd_mux = cnt_val[31:0];
    else if (sel_tdr1)  rd_mux = shadow_q;
    else if (sel_tier)  rd_mux[NUM_CH-1:0] = tier_q;
    else if (sel_tisr)  rd_mux[NUM_CH-1:0] = pend;
    else if (sel_thcsr) rd_mux[1:0] = {halt_ack_status, halt_req_q};
    else begin
      for (int i = 0; i < NUM_CH; i++) begin
        if (sel_cmp[i]) rd_mux = tim_paddr[2] ? cmp_q[i][63:32] : cmp_q[i][31:0];
      end
    end
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      timer_en_q         <= TCR_RST[TCR_EN_BIT];
      div_en_q           <= TCR_RST[TCR_DIV_EN_BIT];
      div_val_q          <= TCR_RST[TCR_DIV_VAL_LSB +: DIV_W];
      halt_req_q         <= 1'b0;
      tier_q             <= '0;
      shadow_q           <= '0;
      for (int i = 0; i < NUM_CH; i++) cmp_q[i] <= CMP_RST;
      tim_prdata         <= '0;
      counter_clear      <= 1'b0;
      counter_write_sel  <= 2'b00;
      counter_write_data <= '0;
      reg_error_flag     <= 1'b0;
    end else begin
      counter_clear     <= tcr_accept && timer_en_q && !new_en;
      counter_write_sel <= {wr_en && sel_tdr1, wr_en && sel_tdr0};
      reg_error_flag    <= err_d;
      if (wr_en && (sel_tdr0 || sel_tdr1)) counter_write_data <= tdr_wdata;

      if (tcr_accept) begin
        timer_en_q <= new_en;
        div_en_q   <= new_div_en;
        div_val_q  <= new_div_val;
      end
      if (wr_en && sel_tier && tim_pstrb[0])  tier_q     <= tim_pwdata[NUM_CH-1:0];
      if (wr_en && sel_thcsr && tim_pstrb[0]) halt_req_q <= tim_pwdata[0];
      for (int i = 0; i < NUM_CH; i++) begin
        if (wr_en && sel_cmp[i]) begin
          if (tim_paddr[2])
            cmp_q[i][63:32] <= merge_bytes(cmp_q[i][63:32], tim_pwdata, tim_pstrb);
          else
            cmp_q[i][31:0]  <= merge_bytes(cmp_q[i][31:0], tim_pwdata, tim_pstrb);
        end
      end

      if (rd_take) begin
        tim_prdata <= rd_mux;
        // Freeze the upper word so a following TDR1 read pairs with this TDR0.
        if (sel_tdr0) shadow_q <= cnt_val[63:32];
      end
    end
  end

  assign timer_en = timer_en_q;
  assign div_en   = div_en_q;
  assign div_val  = div_val_q;
  assign halt_req = halt_req_q;
  assign tim_int  = |irq;

endmodule

// File: tb/tb_timer_regfile_mc.sv
module tb_timer_regfile_mc;
  localparam int NUM_CH = 4;
  localparam int DIV_W  = 4;

  logic                 sys_clk = 1'b0;
  logic                 sys_rst_n = 1'b0;
  logic                 wr_en = 1'b0, rd_en = 1'b0;
  logic [11:0]          tim_paddr = '0;
  logic [31:0]          tim_pwdata = '0;
  logic [3:0]           tim_pstrb = '0;
  logic [31:0]          tim_prdata;
  logic [63:0]          cnt_val = '0;
  logic                 halt_ack_status = 1'b0;
  logic [NUM_CH-1:0]    cmp_match = '0;
  logic                 timer_en, div_en, halt_req, counter_clear, tim_int, reg_error_flag;
  logic [DIV_W-1:0]     div_val;
  logic [64*NUM_CH-1:0] compare_val;
  logic [1:0]           counter_write_sel;
  logic [31:0]          counter_write_data;

  timer_regfile_mc #(.NUM_CH(NUM_CH), .DIV_W(DIV_W), .CMP_RST(64'hFFFF_FFFF_FFFF_FFFF)) dut (
    .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .wr_en(wr_en), .rd_en(rd_en),
    .tim_paddr(tim_paddr), .tim_pwdata(tim_pwdata), .tim_pstrb(tim_pstrb),
    .tim_prdata(tim_prdata), .cnt_val(cnt_val), .halt_ack_status(halt_ack_status),
    .cmp_match(cmp_match), .timer_en(timer_en), .div_en(div_en), .div_val(div_val),
    .halt_req(halt_req), .compare_val(compare_val), .counter_clear(counter_clear),
    .counter_write_sel(counter_write_sel), .counter_write_data(counter_write_data),
    .tim_int(tim_int), .reg_error_flag(reg_error_flag)
  );

  always #5 sys_clk = ~sys_clk;

  typedef struct {
    bit          chk_rd;
    logic [31:0] rdata;
    bit          err;
    bit          clr;
    logic [1:0]  wsel;
    logic [31:0] wdata;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // An access presents its response in the cycle after its strobe edge.
  logic acc_d = 1'b0;
  always @(posedge sys_clk) acc_d <= (wr_en | rd_en) & sys_rst_n;

  exp_t mon_e;
  always @(negedge sys_clk) begin
    if (acc_d) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_access", 1, 0);
      end else begin
        mon_e = exp_q.pop_front();
        if (mon_e.chk_rd) chk("prdata", tim_prdata, mon_e.rdata);
        chk("err_flag", reg_error_flag, mon_e.err);
        chk("counter_clear", counter_clear, mon_e.clr);
        chk("write_sel", counter_write_sel, mon_e.wsel);
        if (mon_e.wsel != 2'b00) chk("write_data", counter_write_data, mon_e.wdata);
      end
    end else begin
      // Pulses must be confined to the single cycle after an access.
      chk("idle_pulses", {reg_error_flag, counter_clear, counter_write_sel}, 0);
    end
  end

  task automatic access(input bit we, input bit re, input logic [11:0] a,
                        input logic [31:0] d, input logic [3:0] s,
                        input logic [NUM_CH-1:0] m, input exp_t e);
    exp_q.push_back(e);
    @(posedge sys_clk); #1;
    wr_en = we; rd_en = re; tim_paddr = a; tim_pwdata = d; tim_pstrb = s; cmp_match = m;
    @(posedge sys_clk); #1;
    wr_en = 0; rd_en = 0; cmp_match = '0;
  endtask

  task automatic wr(input logic [11:0] a, input logic [31:0] d, input logic [3:0] s,
                    input bit err, input bit clr, input logic [1:0] wsel, input logic [31:0] wdata);
    exp_t e;
    e.chk_rd = 0; e.rdata = '0; e.err = err; e.clr = clr; e.wsel = wsel; e.wdata = wdata;
    access(1, 0, a, d, s, '0, e);
  endtask

  task automatic rd(input logic [11:0] a, input logic [31:0] data, input bit err);
    exp_t e;
    e.chk_rd = 1; e.rdata = data; e.err = err; e.clr = 0; e.wsel = 2'b00; e.wdata = '0;
    access(0, 1, a, '0, 4'h0, '0, e);
  endtask

  task automatic pulse_match(input logic [NUM_CH-1:0] m);
    @(posedge sys_clk); #1; cmp_match = m;
    @(posedge sys_clk); #1; cmp_match = '0;
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_timer_en"}, timer_en, 0);
    chk({tag, "_div_en"}, div_en, 0);
    chk({tag, "_div_val"}, div_val, 1);
    chk({tag, "_halt_req"}, halt_req, 0);
    chk({tag, "_tim_int"}, tim_int, 0);
    chk({tag, "_prdata"}, tim_prdata, 0);
    chk({tag, "_cmp0"}, compare_val[63:0], 64'hFFFF_FFFF_FFFF_FFFF);
    chk({tag, "_cmp2"}, compare_val[191:128], 64'hFFFF_FFFF_FFFF_FFFF);
    chk({tag, "_pulses"}, {reg_error_flag, counter_clear, counter_write_sel}, 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog");
  end

  initial begin
    exp_t e;
    repeat (3) @(posedge sys_clk);
    #1 sys_rst_n = 1'b1;
    check_reset_outputs("rst");
    rd(12'h000, 32'h0000_0100, 0);
    rd(12'h010, 32'hFFFF_FFFF, 0);
    rd(12'h100, 32'h0, 0);

    // Compare channel 2 full write and read-back; partial-lane write on channel 1
    wr(12'h020, 32'h89AB_CDEF, 4'hF, 0, 0, 2'b00, 0);
    wr(12'h024, 32'h0123_4567, 4'hF, 0, 0, 2'b00, 0);
    chk("cmp2_val", compare_val[191:128], 64'h0123_4567_89AB_CDEF);
    rd(12'h020, 32'h89AB_CDEF, 0);
    rd(12'h024, 32'h0123_4567, 0);
    wr(12'h018, 32'h1122_3344, 4'h5, 0, 0, 2'b00, 0);
    rd(12'h018, 32'hFF22_FF44, 0);

    // Atomic counter read through the shadow
    cnt_val = 64'hAAAA_BBBB_C0C0_DADA;
    rd(12'h004, 32'hC0C0_DADA, 0);
    cnt_val = 64'h1111_2222_3333_4444;
    rd(12'h008, 32'hAAAA_BBBB, 0);

    // TCR lock
    wr(12'h000, 32'h0000_0503, 4'hF, 0, 0, 2'b00, 0);
    chk("tcr_en", {timer_en, div_en, div_val}, {1'b1, 1'b1, 4'd5});
    wr(12'h000, 32'h0000_0603, 4'hF, 1, 0, 2'b00, 0);
    chk("tcr_locked", {timer_en, div_en, div_val}, {1'b1, 1'b1, 4'd5});
    rd(12'h000, 32'h0000_0503, 0);
    wr(12'h000, 32'h0000_0600, 4'hF, 0, 1, 2'b00, 0);
    chk("tcr_stop", {timer_en, div_en, div_val}, {1'b0, 1'b0, 4'd6});

    // Interrupts
    wr(12'h100, 32'h4, 4'hF, 0, 0, 2'b00, 0);
    pulse_match(4'h4);
    chk("tim_int_set", tim_int, 1);
    rd(12'h104, 32'h4, 0);
    e.chk_rd = 0; e.rdata = 0; e.err = 0; e.clr = 0; e.wsel = 2'b00; e.wdata = 0;
    access(1, 0, 12'h104, 32'h4, 4'hF, 4'h4, e);
    rd(12'h104, 32'h4, 0);
    chk("tim_int_setwins", tim_int, 1);
    wr(12'h104, 32'h4, 4'hF, 0, 0, 2'b00, 0);
    rd(12'h104, 32'h0, 0);
    chk("tim_int_clr", tim_int, 0);
    pulse_match(4'h2);
    chk("tim_int_masked", tim_int, 0);
    rd(12'h104, 32'h2, 0);
    wr(12'h104, 32'h2, 4'hF, 0, 0, 2'b00, 0);

    // Counter write commands
    cnt_val = 64'h1234_5678_9ABC_DEF0;
    wr(12'h008, 32'hDEAD_BEEF, 4'h3, 0, 0, 2'b10, 32'h1234_BEEF);
    wr(12'h004, 32'hCAFE_F00D, 4'hC, 0, 0, 2'b01, 32'hCAFE_DEF0);

    // Unmapped and conflicting accesses
    rd(12'h000, 32'h0000_0600, 0);
    rd(12'h200, 32'h0, 1);
    wr(12'h00C, 32'hFFFF_FFFF, 4'hF, 1, 0, 2'b00, 0);
    rd(12'h000, 32'h0000_0600, 0);
    e.chk_rd = 1; e.rdata = 32'h0000_0600; e.err = 1; e.clr = 0; e.wsel = 2'b00; e.wdata = 0;
    access(1, 1, 12'h100, 32'h1, 4'hF, '0, e);
    rd(12'h100, 32'h1, 0);

    // Halt handshake
    wr(12'h108, 32'h1, 4'hF, 0, 0, 2'b00, 0);
    chk("halt_req", halt_req, 1);
    halt_ack_status = 1'b1;
    rd(12'h108, 32'h3, 0);

    // Reset asserted during a write
    wr(12'h020, 32'h0, 4'hF, 0, 0, 2'b00, 0);
    pulse_match(4'h1);
    chk("pre_rst_int", tim_int, 1);
    @(posedge sys_clk); #1;
    wr_en = 1; tim_paddr = 12'h000; tim_pwdata = 32'h0000_0503; tim_pstrb = 4'hF;
    #2 sys_rst_n = 1'b0;
    @(posedge sys_clk); #1;
    wr_en = 0;
    check_reset_outputs("midrst");
    @(posedge sys_clk); #1 sys_rst_n = 1'b1;
    @(posedge sys_clk); #1;
    check_reset_outputs("postrst");
    rd(12'h104, 32'h0, 0);
    rd(12'h000, 32'h0000_0100, 0);

    repeat (2) @(posedge sys_clk);
    chk("queue_drained", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule

// File: doc/timer_regfile_mc.md
Name: timer_regfile_mc

Overview:
- Multi-channel successor to the single-compare timer register file.
- Sits between the APB slave front-end (wr_en/rd_en strobes) and the timer core (divider, 64-bit counter, NUM_CH compare units).
- Holds control, per-channel compare and interrupt registers. Provides an atomic 64-bit counter read via a shadow of the upper word.
- Emits one-cycle command pulses to the core and a merged interrupt.

Parameters:
NUM_CH, 4, number of compare/interrupt channels (1..8)
DIV_W, 4, width of div_val
CMP_RST, 64'hFFFF_FFFF_FFFF_FFFF, reset value of every compare register

Ports:
sys_clk  in  1  clock
sys_rst_n  in  1  asynchronous active-low reset
wr_en  in  1  write access strobe, one cycle
rd_en  in  1  read access strobe, one cycle
tim_paddr  in  12  byte address, word aligned
tim_pwdata  in  32  write data
tim_pstrb  in  4  byte-lane write enables
tim_prdata  out  32  registered read data
cnt_val  in  64  live counter value
halt_ack_status  in  1  core halt acknowledge
cmp_match  in  NUM_CH  one-cycle compare-hit pulses from core
timer_en  out  1  TCR[0]
div_en  out  1  TCR[1]
div_val  out  DIV_W  TCR[8+:DIV_W]
halt_req  out  1  THCSR[0]
compare_val  out  64*NUM_CH  channel i at [64i+:64]
counter_clear  out  1  pulse on TCR timer_en 1->0 write
counter_write_sel  out  2  pulse: bit0=low word, bit1=high word
counter_write_data  out  32  data accompanying counter_write_sel
tim_int  out  1  OR of (pending & enable)
reg_error_flag  out  1  one-cycle error pulse

Behaviour:
- Register map:
  - 0x000 TCR.
  - 0x004 TDR0 (cnt_val low).
  - 0x008 TDR1 (shadow high).
  - 0x010+8i TCMPi low, 0x014+8i TCMPi high, for i<NUM_CH.
  - 0x100 TIER [NUM_CH-1:0].
  - 0x104 TISR [NUM_CH-1:0], W1C.
  - 0x108 THCSR: [0] halt_req RW, [1] halt_ack RO.
  - All else unmapped.
- Writes take effect on the sys_clk edge where wr_en=1, byte lanes gated by tim_pstrb. Outputs reflect the new value the cycle after.
- Reads: tim_prdata loads on the edge where rd_en=1 and holds otherwise. Unused bits read 0. Unmapped reads return 0.
- Atomic read: reading TDR0 returns cnt_val[31:0] and in the same edge latches cnt_val[63:32] into the shadow. TDR1 returns the shadow, not the live value.
- TDR0/TDR1 write: counter_write_sel = 01/10 and counter_write_data = merged pwdata for exactly one cycle after the write edge. Strobe-disabled bytes are taken from cnt_val.
- TCR lock: a write that changes div_en or div_val while timer_en is currently 1 is rejected.
  - The whole TCR is unchanged, including timer_en.
  - reg_error_flag pulses one cycle.
- A TCR write that clears timer_en and also changes div fields is legal.
- Any wr_en or rd_en to an unmapped address is ignored and pulses reg_error_flag.
- counter_clear pulses one cycle when an accepted TCR write takes timer_en 1->0.
- TISR:
  - Bit i sets on cmp_match[i].
  - Writing 1 clears it.
  - Simultaneous match and W1C on the same bit: set wins.
- tim_int is combinational from registered state.
- Halt: halt_req is plain RW. halt_ack_status is sampled directly into THCSR[1] on read.
- Reset values:
  - TCR = 0x0000_0100 (div_val=1), giving timer_en=0, div_en=0.
  - Compares = CMP_RST; TIER = 0; TISR = 0; halt_req = 0; shadow = 0.
  - tim_prdata = 0; all pulses = 0; tim_int = 0.
- Reset mid-access aborts the access and leaves no pending pulse.
- wr_en and rd_en both high: write takes priority, the read is ignored, and reg_error_flag pulses.

Decomposition:
- Shared package timer_pkg holds:
  - address offsets;
  - TCR field positions;
  - TCR reset constant;
  - the NUM_CH upper limit.
- One sub-module, timer_irq_ch: a single pending bit with set-wins W1C plus enable gating, instantiated NUM_CH times.

Test Plan:
- NUM_CH=4. Write TCMP2 low 0x89ABCDEF and high 0x01234567 with pstrb=F -> compare_val[191:128]=0x01234567_89ABCDEF; read back of both words matches.
- cnt_val=0xAAAABBBB_C0C0DADA, read TDR0; change cnt_val to 0x11112222_33334444; read TDR1 -> 0xC0C0DADA then 0xAAAABBBB.
- Write TCR 0x503 -> timer_en=1, div_en=1, div_val=5. Then write TCR 0x603 -> reg_error_flag pulses one cycle and div_val stays 5. Then write TCR 0x600 -> accepted, counter_clear pulses, div_val=6.
- TIER=0x4; pulse cmp_match[2] -> TISR=0x4, tim_int=1. Write TISR=0x4 in the same cycle as a new cmp_match[2] -> TISR stays 0x4. Next W1C alone -> 0, tim_int=0.
- Write TDR1 0xDEADBEEF with pstrb=0x3 while cnt_val[63:32]=0x12345678 -> one-cycle counter_write_sel=10, counter_write_data=0x1234BEEF.
- Read 0x200 -> tim_prdata=0 and reg_error_flag pulses. Assert sys_rst_n low mid-write -> all outputs return to reset values.
